stopwatch_datapath: RTL and testbench
=====================================

STOPWATCH_DATAPATH -- requirements
Module: stopwatch_datapath

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 100, meaning centisecond tick rate in Hz; CLK_FREQ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_run_stop, input, 1 bit: debounced level from a push button, asynchronous to clk.
REQ-006 The block SHALL have port btn_clear, input, 1 bit: debounced level from a push button, asynchronous to clk.
REQ-007 The block SHALL have port msec, output, 7 bits: centiseconds, 0..99, registered.
REQ-008 The block SHALL have port sec, output, 6 bits: seconds, 0..59, registered.
REQ-009 The block SHALL have port min, output, 6 bits: minutes, 0..59, registered.
REQ-010 The block SHALL have port running, output, 1 bit: high while the FSM is in RUN.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle pulse per press; holding a button SHALL produce no further pulses.
REQ-012 Latency: a button rising before clk edge k SHALL change the state at edge k+2.
REQ-013 The FSM SHALL have three states: STOP, RUN and CLEAR.
REQ-014 In STOP, a run_stop pulse SHALL go to RUN, a clear pulse SHALL go to CLEAR, and otherwise the FSM SHALL stay in STOP.
REQ-015 In RUN, a run_stop pulse SHALL go to STOP; clear pulses SHALL be ignored.
REQ-016 CLEAR SHALL last exactly one cycle and then go to STOP; button pulses during CLEAR SHALL be ignored.
REQ-017 If both pulses arrive in the same cycle while in STOP, run_stop SHALL win and the FSM SHALL go to RUN.
REQ-018 The prescaler SHALL count 0..CLK_FREQ/TICK_HZ-1 only while the state register equals RUN, and SHALL issue a 1-cycle tick on its terminal count.
REQ-019 The prescaler SHALL hold its value in STOP, so a resume continues the partial period, and SHALL be zeroed in CLEAR.
REQ-020 On a tick, msec SHALL increment; at 99 it SHALL wrap to 0 and increment sec.
REQ-021 sec SHALL wrap 59 to 0 and increment min.
REQ-022 min SHALL wrap 59 to 0, so 59:59.99 is followed by 00:00.00, with no saturation and no flag.
REQ-023 A tick in the same cycle as a run_stop pulse in RUN SHALL still be counted, because the state register was RUN in that cycle.
REQ-024 All counter updates on one tick SHALL occur in the same clk edge; outputs SHALL never show intermediate values.
REQ-025 In CLEAR, msec, sec, min and the prescaler SHALL be 0 at the following edge.
REQ-026 Outputs SHALL never exceed their stated ranges.

Reset
REQ-027 rst low SHALL asynchronously force state STOP, msec/sec/min to 0, running to 0, the prescaler to 0, and the synchronizer and edge flops to 0.
REQ-028 Reset asserted mid-count SHALL discard the partial prescaler period.
REQ-029 After rst deasserts, a button already held high SHALL produce one pulse, since the edge flops reset to 0.

Structure
REQ-030 The state encoding (STOP=2'd0, RUN=2'd1, CLEAR=2'd2) and the wrap limits (99, 59, 59) SHALL live in a shared stopwatch package/include file.
REQ-031 One sub-module, btn_edge_detector (sync plus edge, 1 bit), SHALL be instantiated twice.
REQ-032 The datapath output SHALL feed the display controller's msec and sec inputs directly, with widths matching.

Verification (CLK_FREQ=1000, TICK_HZ=100, i.e. a tick every 10 clk)
REQ-033 The bench SHALL cover: reset, then press run_stop and wait 1000 cycles -> running=1, msec advances 1 per 10 clk, with msec=99 followed by msec=0, sec=1.
REQ-034 The bench SHALL cover: preload by running to 59:59.99, then one tick -> min=0, sec=0, msec=0 on the same edge.
REQ-035 The bench SHALL cover: stop at prescaler=4, idle 50 cycles, resume -> next tick exactly 6 cycles later, with values frozen during STOP.
REQ-036 The bench SHALL cover: press clear while in RUN -> ignored; press stop, then clear -> one CLEAR cycle, all outputs 0, running=0.
REQ-037 The bench SHALL cover: run_stop and clear pulsed in the same cycle from STOP -> RUN with counters not cleared; run_stop held 100 cycles -> exactly one toggle.
REQ-038 The bench SHALL cover: rst pulled low mid-run with msec=37 -> all outputs 0 immediately, without waiting for clk, and STOP after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, counter wrap limits and
// prescaler width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

  localparam logic [6:0] MSEC_MAX = 7'd99;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/btn_edge_detector.sv
// Two-flop synchronizer followed by a rising-edge detector; emits one
// clk-wide pulse per press of an asynchronous, debounced button level.
module btn_edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Edge flops clear on reset, so a button held through reset yields one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch core: run/stop/clear FSM, centisecond prescaler and
// mm:ss.cc counter chain with registered outputs.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       running
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    msec_q,  msec_d;
  logic [5:0]    sec_q,   sec_d;
  logic [5:0]    min_q,   min_d;
  logic          run_pulse, clr_pulse, tick;

  btn_edge_detector u_run_edge (
    .clk    (clk),
    .rst_n  (rst),
    .btn_in (btn_run_stop),
    .pulse  (run_pulse)
  );

  btn_edge_detector u_clr_edge (
    .clk    (clk),
    .rst_n  (rst),
    .btn_in (btn_clear),
    .pulse  (clr_pulse)
  );

  // run_stop has priority over clear when both arrive in STOP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (run_pulse)      state_d = ST_RUN;
        else if (clr_pulse) state_d = ST_CLEAR;
      end
      ST_RUN:   if (run_pulse) state_d = ST_STOP;
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  // Gated on the registered state, so a tick coinciding with a stop press still counts.
  always_comb begin
    presc_d = presc_q;
    msec_d  = msec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    if (state_q == ST_CLEAR) begin
      presc_d = '0;
      msec_d  = '0;
      sec_d   = '0;
      min_d   = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (msec_q >= MSEC_MAX) begin
          msec_d = '0;
          if (sec_q >= SEC_MAX) begin
            sec_d = '0;
            min_d = (min_q >= MIN_MAX) ? '0 : min_q + 6'd1;
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          msec_d = msec_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      msec_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      msec_q  <= msec_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
    end
  end

  assign msec    = msec_q;
  assign sec     = sec_q;
  assign min     = min_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed bench for stopwatch_datapath at CLK_FREQ=1000, TICK_HZ=100
// (one centisecond tick every 10 clk); expectations flow through a queue.
module tb_stopwatch_datapath;

  typedef struct {
    string      tag;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic       running;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_run_stop;
  logic       btn_clear;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic       running;

  exp_t sb[$];
  int unsigned tests_run = 0;
  int unsigned failures  = 0;

  stopwatch_datapath #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_run_stop (btn_run_stop),
    .btn_clear    (btn_clear),
    .msec         (msec),
    .sec          (sec),
    .min          (min),
    .running      (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_front();
    exp_t e;
    logic [19:0] obs, want;
    e    = sb.pop_front();
    obs  = {running, min, sec, msec};
    want = {e.running, e.min, e.sec, e.msec};
    tests_run++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed run=%0b %0d:%0d.%0d expected run=%0b %0d:%0d.%0d",
             e.tag, running, min, sec, msec, e.running, e.min, e.sec, e.msec);
    end
  endtask

  task automatic step(input int unsigned n, input string tag,
                      input logic [6:0] ems, input logic [5:0] es,
                      input logic [5:0] em, input logic er);
    exp_t e;
    e.tag = tag; e.msec = ems; e.sec = es; e.min = em; e.running = er;
    sb.push_back(e);
    cyc(n);
    check_front();
  endtask

  initial begin
    rst = 1'b0;
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
    #3;
    step(0, "reset_hold", 0, 0, 0, 0);
    cyc(2);
    rst = 1'b1;
    step(1, "post_reset", 0, 0, 0, 0);

    // Start: state changes on the third edge after the button rises.
    btn_run_stop = 1'b1;
    step(2, "run_latency", 0, 0, 0, 0);
    step(1, "run_entered", 0, 0, 0, 1);
    btn_run_stop = 1'b0;
    for (int i = 1; i <= 5; i++) step(10, "cs_step", 7'(i), 0, 0, 1);
    step(940, "msec_99", 99, 0, 0, 1);
    step(10, "msec_wrap", 0, 1, 0, 1);

    // Stop with prescaler at 4, idle, resume: tick 6 edges after resume.
    step(1, "pre_stop", 0, 1, 0, 1);
    btn_run_stop = 1'b1;
    step(3, "stopped", 0, 1, 0, 0);
    btn_run_stop = 1'b0;
    step(50, "frozen", 0, 1, 0, 0);
    btn_run_stop = 1'b1;
    step(3, "resumed", 0, 1, 0, 1);
    btn_run_stop = 1'b0;
    step(5, "before_tick", 0, 1, 0, 1);
    step(1, "tick_after_6", 1, 1, 0, 1);

    btn_clear = 1'b1;
    step(3, "clear_in_run", 1, 1, 0, 1);
    btn_clear = 1'b0;
    step(7, "run_after_clear", 2, 1, 0, 1);

    btn_run_stop = 1'b1;
    step(3, "stop2", 2, 1, 0, 0);
    btn_run_stop = 1'b0;
    step(5, "frozen2", 2, 1, 0, 0);

    // Both buttons together from STOP, then run_stop held for 100 cycles.
    btn_run_stop = 1'b1;
    btn_clear = 1'b1;
    step(3, "both_run", 2, 1, 0, 1);
    btn_clear = 1'b0;
    step(1, "both_no_clear", 2, 1, 0, 1);
    step(50, "held_mid", 7, 1, 0, 1);
    step(46, "held_end", 12, 1, 0, 1);
    btn_run_stop = 1'b0;
    step(6, "released", 12, 1, 0, 1);

    btn_run_stop = 1'b1;
    step(3, "stop3", 12, 1, 0, 0);
    btn_run_stop = 1'b0;
    btn_clear = 1'b1;
    step(3, "clear_entry", 12, 1, 0, 0);
    btn_clear = 1'b0;
    step(1, "cleared", 0, 0, 0, 0);
    step(5, "stay_cleared", 0, 0, 0, 0);

    // Preload 59:59.99 while stopped; the forced value is captured by a hold edge.
    force dut.msec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    cyc(1);
    release dut.msec_q;
    release dut.sec_q;
    release dut.min_q;
    step(0, "preload", 99, 59, 59, 0);
    btn_run_stop = 1'b1;
    step(3, "run_from_preload", 99, 59, 59, 1);
    btn_run_stop = 1'b0;
    step(9, "last_cs", 99, 59, 59, 1);
    step(1, "full_wrap", 0, 0, 0, 1);
    step(10, "after_wrap", 1, 0, 0, 1);

    // Asynchronous reset mid-period.
    step(360, "msec_37", 37, 0, 0, 1);
    cyc(3);
    #2;
    rst = 1'b0;
    step(0, "async_reset", 0, 0, 0, 0);
    step(1, "reset_held", 0, 0, 0, 0);
    rst = 1'b1;
    step(3, "stop_after_reset", 0, 0, 0, 0);

    // Button held through reset release gives exactly one pulse.
    rst = 1'b0;
    btn_run_stop = 1'b1;
    cyc(1);
    rst = 1'b1;
    step(2, "held_no_run_yet", 0, 0, 0, 0);
    step(1, "held_pulse", 0, 0, 0, 1);
    step(10, "fresh_period", 1, 0, 0, 1);
    step(50, "single_pulse", 6, 0, 0, 1);
    btn_run_stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
